// File: rtl/sorted_insert_mem.sv
// Sorted lookup-table builder: inserts 8-bit values into an ascending, stable array.
// Latency: an insert with k larger entries takes k+1 busy cycles; rd_data has 1 cycle latency.
// Backpressure: in_ready drops while inserting, when full, and during reset.
//
// Ports:
//   clk, reset    - clock; synchronous active-high reset (highest priority)
//   clear         - synchronous empty request; aborts any insertion in progress
//   in_data/in_valid/in_ready - value-to-insert handshake
//   rd_addr/rd_data - registered read port; slots at or above count read all-ones
//   count/full/busy - number of valid entries, count==DEPTH, insertion in progress
module sorted_insert_mem #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic {
    S_IDLE,
    S_INSERT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     p_q, p_d;       // slot currently being filled
  logic [DATA_W-1:0]   v_q, v_d;       // value being inserted
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Single write port: either a one-slot shift or the final placement.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdat;

  logic [ADDR_W-1:0]   wr_idx;
  logic [ADDR_W-1:0]   prev_idx;
  logic [DATA_W-1:0]   prev_dat;
  logic                do_shift;
  logic                rd_hit;

  assign full     = (count_q == DEPTH_C);
  assign busy     = (state_q == S_INSERT);
  assign in_ready = !reset && (state_q == S_IDLE) && !full;
  assign count    = count_q;
  assign rd_data  = rd_data_q;

  // p never exceeds DEPTH-1 while inserting (accept requires not full),
  // so its low ADDR_W bits address the table directly.
  assign wr_idx   = p_q[ADDR_W-1:0];
  assign prev_idx = wr_idx - ADDR_W'(1);
  assign prev_dat = mem[prev_idx];

  // Strictly-greater compare keeps duplicates after existing equal entries.
  assign do_shift = (p_q != '0) && (prev_dat > v_q);

  // Count is the pre-edge value, so a slot being filled this cycle still reads all-ones.
  assign rd_hit   = ({1'b0, rd_addr} < count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    p_d       = p_q;
    v_d       = v_q;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdat  = v_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (in_valid && in_ready) begin
          v_d     = in_data;
          p_d     = count_q;
          state_d = S_INSERT;
        end
      end

      S_INSERT: begin
        if (clear) begin
          // Shifts already done only touch slots that count=0 masks out.
          count_d = '0;
          state_d = S_IDLE;
        end else if (do_shift) begin
          mem_we   = 1'b1;
          mem_wdat = prev_dat;
          p_d      = p_q - ONE_C;
        end else begin
          mem_we   = 1'b1;
          mem_wdat = v_q;
          count_d  = count_q + ONE_C;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      p_q       <= '0;
      v_q       <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      p_q       <= p_d;
      v_q       <= v_d;
      rd_data_q <= rd_hit ? mem[rd_addr] : '1;
    end
  end

  // Table storage is not reset; unused slots are masked on read.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

endmodule

// File: tb/tb_sorted_insert_mem.sv
module tb_sorted_insert_mem;

  localparam int DEPTH = 32;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic       full;
  logic       busy;

  sorted_insert_mem #(.DEPTH(32), .ADDR_W(5), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The table is a sorted queue; an accepted value becomes visible after
  // (number of larger entries + 1) cycles, then lands after its equals.
  logic [7:0] q[$];
  bit         m_busy = 1'b0;
  int         m_rem  = 0;
  logic [7:0] m_v    = '0;
  logic [7:0] exp_rd = '0;
  bit         rd_chk = 1'b0;
  bit         chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_busy = 1'b0;
        m_rem  = 0;
        exp_rd = 8'h00;
        rd_chk = 1'b1;
        chk_en = 1'b1;
      end else begin
        rd_chk = !m_busy;
        exp_rd = (int'(rd_addr) < q.size()) ? q[rd_addr] : 8'hFF;
        if (clear) begin
          q.delete();
          m_busy = 1'b0;
          m_rem  = 0;
        end else if (m_busy) begin
          m_rem--;
          if (m_rem == 0) begin
            int k;
            k = 0;
            foreach (q[i]) if (q[i] > m_v) k++;
            q.insert(q.size() - k, m_v);
            m_busy = 1'b0;
          end
        end else if (in_valid && q.size() < DEPTH) begin
          int k;
          m_v = in_data;
          k = 0;
          foreach (q[i]) if (q[i] > m_v) k++;
          m_rem  = k + 1;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Compare every cycle once the first reset edge has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("count",    count,    q.size());
        check("busy",     busy,     m_busy);
        check("full",     full,     q.size() == DEPTH);
        check("in_ready", in_ready, !reset && !m_busy && q.size() < DEPTH);
        if (rd_chk) check("rd_data", rd_data, exp_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    rd_addr = 5'(addr);
    tick;
    check("rd_lit", rd_data, exp);
  endtask

  task automatic do_insert(input logic [7:0] v, input int exp_cyc, input bit hold);
    int t;
    int n;
    t = 0;
    while (!in_ready && t < 200) begin
      tick;
      t++;
    end
    check("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    tick;
    if (!hold) in_valid = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      if (hold) check("ready_busy", in_ready, 0);
      n++;
      tick;
    end
    in_valid = 1'b0;
    check("busy_cycles", n, exp_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    rd_addr  = '0;
    tick;
    tick;
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_busy",  busy, 0);
    check("rst_rd",    rd_data, 0);

    // Empty table reads all-ones everywhere.
    for (int a = 0; a < DEPTH; a++) rd(a, 8'hFF);
    check("empty_ready", in_ready, 1);

    // In-order inserts: one busy cycle each.
    do_insert(8'd10, 1, 1'b0);
    do_insert(8'd20, 1, 1'b0);
    do_insert(8'd30, 1, 1'b0);
    check("cnt3", count, 3);
    rd(0, 8'd10); rd(1, 8'd20); rd(2, 8'd30); rd(3, 8'hFF);

    // Smallest value shifts all three: four busy cycles, in_valid held.
    do_insert(8'd5, 4, 1'b1);
    tick;
    check("cnt4", count, 4);
    rd(0, 8'd5); rd(1, 8'd10); rd(2, 8'd20); rd(3, 8'd30);

    // Duplicate goes after the existing 20.
    do_insert(8'd20, 2, 1'b0);
    rd(0, 8'd5); rd(1, 8'd10); rd(2, 8'd20); rd(3, 8'd20); rd(4, 8'd30); rd(5, 8'hFF);
    check("cnt5", count, 5);

    // Fill with descending values: each shifts everything already present.
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr_cnt", count, 0);
    for (int i = 0; i < DEPTH; i++) do_insert(8'(31 - i), i + 1, 1'b0);
    check("full", full, 1);
    check("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    tick; tick; tick;
    in_valid = 1'b0;
    check("full_cnt", count, 32);
    for (int a = 0; a < DEPTH; a++) rd(a, 8'(a));

    // Clear in the third cycle of an insertion into eight entries.
    clear = 1'b1;
    tick;
    clear = 1'b0;
    for (int i = 1; i <= 8; i++) do_insert(8'(i * 10), 1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd0;
    tick;
    in_valid = 1'b0;
    check("mid_busy", busy, 1);
    tick;
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("abort_cnt",  count, 0);
    check("abort_busy", busy, 0);
    for (int a = 0; a < 8; a++) rd(a, 8'hFF);

    // Reset wins over a simultaneous insert request.
    do_insert(8'd42, 1, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    #1;
    check("rst_ready", in_ready, 0);
    tick;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rstv_cnt",  count, 0);
    check("rstv_busy", busy, 0);
    check("rstv_rd",   rd_data, 0);
    tick;
    check("rstv_cnt2", count, 0);

    // Random traffic, checked cycle-by-cycle by the model.
    for (int c = 0; c < 2500; c++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) in_data = 8'($urandom_range(0, 7) * 32);
      rd_addr  = 5'($urandom_range(0, 31));
      clear    = ($urandom_range(0, 149) == 0);
      reset    = ($urandom_range(0, 799) == 0);
      tick;
    end
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    tick;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sorted_insert_mem.md
Name: sorted_insert_mem

Overview:
- Upstream feeder for binary_search: builds the sorted lookup table that the search stage reads.
- Accepts 8-bit values one at a time over a valid/ready handshake and inserts each into a sorted array (ascending, stable) by insertion-shift, one element moved per cycle.
- Exposes a registered read port that binary_search drives with its address; unused slots read as all-ones so the table is always sorted end to end.

Parameters:
DEPTH, 32, number of table entries
ADDR_W, 5, read address width (log2 DEPTH)
DATA_W, 8, entry width

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high; highest priority
clear  input  1  synchronous empty request; sets count to 0
in_data  input  DATA_W  value to insert
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block can accept; high only in IDLE, not full, reset low
rd_addr  input  ADDR_W  read address from search stage
rd_data  output  DATA_W  registered read data, 1-cycle latency
count  output  ADDR_W+1  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
busy  output  1  insertion in progress (state INSERT)

Behaviour:
- Reset: state IDLE, count=0, busy=0, full=0, rd_data=0, in_ready=0 during reset cycle. Array contents need not be cleared; unused slots are masked on read.
- States: IDLE and INSERT. Internal pointer p (ADDR_W+1 bits) and held value v.
- Accept: an edge with in_valid && in_ready latches v<=in_data, p<=count, and moves to INSERT. in_data is ignored at all other times.
- INSERT step, one per cycle:
  - If p>0 and mem[p-1] > v: mem[p]<=mem[p-1], p<=p-1, stay in INSERT.
  - Else (p==0 or mem[p-1] <= v): mem[p]<=v, count<=count+1, go to IDLE.
- Ordering: the compare is strictly greater, so a duplicate is placed after existing equal entries.
- Latency: k entries greater than v means k+1 INSERT cycles. busy is high for exactly those cycles. in_ready is high again the cycle after count updates.
- Full: when count==DEPTH, in_ready=0 and in_valid is ignored. full is combinational from count.
- clear:
  - In IDLE: count<=0 next edge.
  - In INSERT: aborts the insertion, count<=0, state<=IDLE. No partial write is committed beyond shifts already done, which are harmless because count=0.
  - clear together with in_valid in IDLE: clear wins, nothing accepted.
- reset with any other event: reset wins.
- Read port:
  - rd_data <= (rd_addr < count) ? mem[rd_addr] : all-ones, registered every cycle.
  - count in the compare is the value before the edge.
  - While busy, reads return in-progress contents. The search stage must start only when busy=0.
- Widths: count and p are ADDR_W+1 bits so DEPTH is representable. No arithmetic wraps; p never decrements below 0.

Test Plan:
- Reset, then read addr 0..31 -> rd_data=8'hFF each (one cycle after addr), count=0, in_ready=1, busy=0.
- Insert 10, 20, 30 in order -> each takes 1 INSERT cycle (busy high 1 cycle); reads give 10, 20, 30, then FF at addr 3; count=3.
- With {10,20,30} present, insert 5 -> busy high 4 cycles; array 5, 10, 20, 30; count=4; in_ready low during busy with in_valid held high, and no extra accept.
- Insert duplicate 20 into {5,10,20,30} -> 2 cycles; array 5, 10, 20, 20, 30; ordering stable.
- Fill to 32 entries with values 31 down to 0 -> full=1, in_ready=0; a further in_valid with 99 has no effect; addr 0..31 read 0..31.
- Assert clear mid-insert (inserting 0 into 8 entries, 3rd busy cycle) -> next cycle count=0, busy=0, all reads FF. Assert reset together with in_valid -> nothing accepted, count=0.
